// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates nickel/dime credit, dispenses at PRICE, pays change as nickel pulses.
// Optional refund-on-cancel support is compiled in with `define VEND_REFUND_EN.

module adder_3bit (
   input  logic [2:0] a,
   input  logic [2:0] b,
   input  logic       cin,
   output logic [2:0] sum,
   output logic       cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {3'b000, cin};
endmodule

module vend_credit_ctrl #(
   parameter logic [2:0] PRICE = 3'd4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_nickel,
   input  logic       i_dime,
   input  logic       i_cancel,
   output logic [2:0] o_credit,
   output logic       o_dispense,
   output logic       o_change_nickel,
   output logic       o_coin_rej,
   output logic       o_busy
);

   // Handshake: coin and cancel inputs are single-cycle pulses sampled at the
   // rising edge; every output is a register and each pulse lasts one cycle.

`ifdef VEND_REFUND_EN
   localparam logic REFUND_EN = 1'b1;
`else
   localparam logic REFUND_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DISPENSE, S_CHANGE} state_t;

   state_t     state;
   logic [2:0] coin_val;
   logic [2:0] add_b;
   logic [2:0] add_sum;
   logic       add_cout;
   logic       coin_any;
   logic       coin_bad;
   logic       cancel_req;

   always_comb begin
      coin_any   = i_nickel | i_dime;
      coin_bad   = i_nickel & i_dime;
      coin_val   = 3'd0;
      if (!coin_bad && i_nickel) coin_val = 3'd1;
      if (!coin_bad && i_dime)   coin_val = 3'd2;
      cancel_req = REFUND_EN & i_cancel & (state == S_ACCUM);
      // The single adder counts coins up, or counts change down by adding -1.
      add_b = 3'd0;
      case (state)
         S_IDLE, S_ACCUM: add_b = coin_val;
         S_CHANGE:        add_b = 3'b111;
         default:         add_b = 3'd0;
      endcase
   end

   adder_3bit u_adder (
      .a    (o_credit),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= S_IDLE;
         o_credit        <= 3'd0;
         o_dispense      <= 1'b0;
         o_change_nickel <= 1'b0;
         o_coin_rej      <= 1'b0;
         o_busy          <= 1'b0;
      end else begin
         o_dispense      <= 1'b0;
         o_change_nickel <= 1'b0;
         o_coin_rej      <= 1'b0;
         case (state)
            S_IDLE, S_ACCUM: begin
               if (cancel_req) begin
                  state           <= S_CHANGE;
                  o_change_nickel <= 1'b1;
                  o_busy          <= 1'b1;
                  o_coin_rej      <= coin_any;
               end else if (coin_bad) begin
                  o_coin_rej <= 1'b1;
               end else if (coin_any) begin
                  o_credit <= add_sum;
                  if (add_sum >= PRICE) begin
                     state      <= S_DISPENSE;
                     o_dispense <= 1'b1;
                     o_busy     <= 1'b1;
                  end else begin
                     state <= S_ACCUM;
                  end
               end
            end
            S_DISPENSE: begin
               o_coin_rej <= coin_any;
               o_credit   <= o_credit - PRICE;
               if (o_credit != PRICE) begin
                  state           <= S_CHANGE;
                  o_change_nickel <= 1'b1;
               end else begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end
            end
            S_CHANGE: begin
               o_coin_rej <= coin_any;
               // A missing carry would mean credit wrapped below zero; treat as done.
               if (add_sum == 3'd0 || !add_cout) begin
                  state    <= S_IDLE;
                  o_credit <= 3'd0;
                  o_busy   <= 1'b0;
               end else begin
                  o_credit        <= add_sum;
                  o_change_nickel <= 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               o_credit <= 3'd0;
               o_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl with PRICE=4; inputs change and outputs are sampled on the falling edge.

module tb_vend_credit_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       nickel = 1'b0;
   logic       dime = 1'b0;
   logic       cancel = 1'b0;
   logic [2:0] credit;
   logic       dispense;
   logic       change_nickel;
   logic       coin_rej;
   logic       busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vend_credit_ctrl #(.PRICE(3'd4)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_nickel        (nickel),
      .i_dime          (dime),
      .i_cancel        (cancel),
      .o_credit        (credit),
      .o_dispense      (dispense),
      .o_change_nickel (change_nickel),
      .o_coin_rej      (coin_rej),
      .o_busy          (busy)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packed view {credit, dispense, change, rej, busy} for compact checks.
   task automatic chk_all(input string tag, input logic [2:0] c, input logic d,
                          input logic ch, input logic r, input logic b);
      chk(tag, {1'b0, credit, dispense, change_nickel, coin_rej, busy},
          {1'b0, c, d, ch, r, b});
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Present inputs for one rising edge, return in the cycle after it.
   task automatic drive(input logic n, input logic d, input logic c);
      nickel = n;
      dime   = d;
      cancel = c;
      @(negedge clk);
      nickel = 1'b0;
      dime   = 1'b0;
      cancel = 1'b0;
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      repeat (10) step();
      chk_all("reset_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Four nickels, one every two cycles.
      drive(1, 0, 0); chk("n1_credit", {5'd0, credit}, 8'd1); step();
      drive(1, 0, 0); chk("n2_credit", {5'd0, credit}, 8'd2); step();
      drive(1, 0, 0); chk("n3_credit", {5'd0, credit}, 8'd3); step();
      drive(1, 0, 0); chk_all("n4_dispense", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      step();         chk_all("n4_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Dime, nickel, dime: one nickel of change.
      drive(0, 1, 0); chk("dnd_credit2", {5'd0, credit}, 8'd2);
      drive(1, 0, 0); chk("dnd_credit3", {5'd0, credit}, 8'd3);
      drive(0, 1, 0); chk_all("dnd_dispense", 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      step();         chk_all("dnd_change", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      step();         chk_all("dnd_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Both coins in one cycle is rejected without touching credit.
      drive(1, 0, 0); chk("ill_pre", {5'd0, credit}, 8'd1);
      drive(1, 1, 0); chk_all("ill_rej", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      step();         chk_all("ill_after", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Dime arriving during the change pulse is bounced.
      drive(0, 1, 0); chk("busy_credit3", {5'd0, credit}, 8'd3);
      drive(0, 1, 0); chk_all("busy_dispense", 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      step();         chk_all("busy_change", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(0, 1, 0); chk_all("busy_rej", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();         chk_all("busy_after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Cancel after dime + nickel.
      drive(0, 1, 0);
      drive(1, 0, 0); chk("can_credit3", {5'd0, credit}, 8'd3);
      drive(0, 0, 1);
`ifdef VEND_REFUND_EN
      chk_all("can_ref3", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
      step(); chk_all("can_ref2", 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
      step(); chk_all("can_ref1", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(); chk_all("can_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Reset while two nickels of refund remain.
      drive(0, 1, 0);
      drive(0, 0, 1); chk_all("rst_pre", 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
`else
      chk_all("can_ignored", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_all("can_held", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      // Reset right after a dispense that would owe one nickel.
      drive(0, 1, 0); chk_all("rst_pre", 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_all("rst_abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_all("rst_quiet1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); chk_all("rst_quiet2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Fresh purchase after reset still works.
      drive(0, 1, 0);
      drive(0, 1, 0); chk_all("post_dispense", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      step();         chk_all("post_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
